// File: rtl/pci_reset_sequencer.sv
// pci_reset_sequencer: drives the PCI reset pad on software request and derives a
// synchronized, stretched core reset from the pad reset input.
module pci_reset_sequencer #(
    parameter int OUT_CYCLES     = 64,
    parameter int RELEASE_CYCLES = 8
) (
    input  logic       pci_clk,
    input  logic       pci_host_reset_l,
    input  logic       pci_reset_raw,
    input  logic       sw_reset_request,
    input  logic       pci_host_mode,
    output logic       pci_reset_out_oe_comb,
    output logic       pci_reset_int,
    output logic       reset_out_busy,
    output logic [7:0] reset_event_count
);
    localparam logic [9:0] OUT_LOAD = 10'(OUT_CYCLES - 1);
    localparam logic [7:0] REL_LOAD = 8'(RELEASE_CYCLES);

    typedef enum logic [1:0] {IDLE, DRIVE, RECOVER} state_t;

    state_t     state, state_next;
    logic       sync1, raw_sync, raw_sync_d;
    logic [1:0] boot;
    logic [9:0] drive_cnt;
    logic [7:0] rel_cnt;

    always_ff @(posedge pci_clk or negedge pci_host_reset_l) begin
        if (!pci_host_reset_l) state <= IDLE;
        else                   state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sw_reset_request && pci_host_mode) state_next = DRIVE;
            DRIVE:   if (drive_cnt == 10'd0 || !pci_host_mode) state_next = RECOVER;
            RECOVER: if (!raw_sync) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // boot flushes for two edges after power-up so the first release matches
    // the normal pad-deassert latency through the synchronizer.
    always_ff @(posedge pci_clk or negedge pci_host_reset_l) begin
        if (!pci_host_reset_l) begin
            sync1                 <= 1'b0;
            raw_sync              <= 1'b0;
            raw_sync_d            <= 1'b0;
            boot                  <= 2'b00;
            drive_cnt             <= 10'd0;
            rel_cnt               <= REL_LOAD;
            pci_reset_out_oe_comb <= 1'b0;
            reset_event_count     <= 8'd0;
        end else begin
            sync1                 <= pci_reset_raw;
            raw_sync              <= sync1;
            raw_sync_d            <= raw_sync;
            boot                  <= {boot[0], 1'b1};
            pci_reset_out_oe_comb <= (state_next == DRIVE);
            if (state == IDLE && state_next == DRIVE)
                drive_cnt <= OUT_LOAD;
            else if (state == DRIVE && drive_cnt != 10'd0)
                drive_cnt <= drive_cnt - 10'd1;
            if (raw_sync || state != IDLE || !boot[1])
                rel_cnt <= REL_LOAD;
            else if (rel_cnt != 8'd0)
                rel_cnt <= rel_cnt - 8'd1;
            if (raw_sync && !raw_sync_d && reset_event_count != 8'hFF)
                reset_event_count <= reset_event_count + 8'd1;
        end
    end

    assign pci_reset_int  = (rel_cnt != 8'd0);
    assign reset_out_busy = (state != IDLE);
endmodule

// File: tb/tb_pci_reset_sequencer.sv
// tb_pci_reset_sequencer: directed scenarios for the PCI reset sequencer with
// hand-computed cycle expectations (default parameters).
module tb_pci_reset_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       raw_ext, loop, sw_req, host_mode;
    logic       raw;
    logic       oe, rint, busy;
    logic [7:0] cnt;
    int         total = 0;
    int         bad = 0;

    assign raw = loop ? oe : raw_ext;

    pci_reset_sequencer dut (
        .pci_clk              (clk),
        .pci_host_reset_l     (rst_n),
        .pci_reset_raw        (raw),
        .sw_reset_request     (sw_req),
        .pci_host_mode        (host_mode),
        .pci_reset_out_oe_comb(oe),
        .pci_reset_int        (rint),
        .reset_out_busy       (busy),
        .reset_event_count    (cnt)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; raw_ext = 1'b0; loop = 1'b0; sw_req = 1'b0; host_mode = 1'b1;
        #23;
        total++; if (oe !== 1'b0)   begin bad++; $display("FAIL reset_oe got=%b want=0", oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rint !== 1'b1) begin bad++; $display("FAIL reset_int got=%b want=1", rint); end
        total++; if (cnt !== 8'd0)  begin bad++; $display("FAIL reset_count got=%0d want=0", cnt); end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 9)  begin total++; if (rint !== 1'b1) begin bad++; $display("FAIL powerup_int_e9 got=%b want=1", rint); end end
            if (k == 10) begin total++; if (rint !== 1'b0) begin bad++; $display("FAIL powerup_int_e10 got=%b want=0", rint); end end
        end
        total++; if (cnt !== 8'd0) begin bad++; $display("FAIL powerup_count got=%0d want=0", cnt); end
    endtask

    task automatic test_sw_request();
        int oe_n = 0, busy_n = 0, rise = -1, fall = -1;
        loop = 1'b1; host_mode = 1'b1;
        @(negedge clk) sw_req = 1'b1;
        @(posedge clk); #1 sw_req = 1'b0;
        for (int n = 0; n < 120; n++) begin
            if (oe) oe_n++;
            if (busy) busy_n++;
            if (rint && rise < 0) rise = n;
            if (!rint && rise >= 0 && fall < 0) fall = n;
            @(posedge clk); #1;
        end
        total++; if (oe_n != 64)   begin bad++; $display("FAIL sw_oe_cycles got=%0d want=64", oe_n); end
        total++; if (busy_n != 67) begin bad++; $display("FAIL sw_busy_cycles got=%0d want=67", busy_n); end
        total++; if (rise != 1)    begin bad++; $display("FAIL sw_int_rise got=%0d want=1", rise); end
        total++; if (fall != 75)   begin bad++; $display("FAIL sw_int_fall got=%0d want=75", fall); end
        total++; if (cnt !== 8'd1) begin bad++; $display("FAIL sw_count got=%0d want=1", cnt); end
    endtask

    task automatic test_host_mode_off();
        int oe_n = 0, busy_n = 0;
        loop = 1'b1; host_mode = 1'b0;
        @(negedge clk) sw_req = 1'b1;
        @(posedge clk); #1 sw_req = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (oe) oe_n++;
            if (busy) busy_n++;
            @(posedge clk); #1;
        end
        total++; if (oe_n != 0)    begin bad++; $display("FAIL slave_oe_cycles got=%0d want=0", oe_n); end
        total++; if (busy_n != 0)  begin bad++; $display("FAIL slave_busy_cycles got=%0d want=0", busy_n); end
        total++; if (cnt !== 8'd1) begin bad++; $display("FAIL slave_count got=%0d want=1", cnt); end
    endtask

    task automatic test_back_to_back();
        int oe_n = 0, busy_n = 0;
        loop = 1'b1; host_mode = 1'b1;
        @(negedge clk) sw_req = 1'b1;
        @(posedge clk); #1 sw_req = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (oe) oe_n++;
            if (busy) busy_n++;
            if (n == 5)  sw_req = 1'b1;
            if (n == 6)  sw_req = 1'b0;
            if (n == 19) host_mode = 1'b0;
            if (n == 25) host_mode = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (oe_n != 20)   begin bad++; $display("FAIL b2b_oe_cycles got=%0d want=20", oe_n); end
        total++; if (busy_n != 23) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=23", busy_n); end
        total++; if (cnt !== 8'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", cnt); end
    endtask

    task automatic test_release();
        loop = 1'b0; raw_ext = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (n == 2) begin total++; if (rint !== 1'b0) begin bad++; $display("FAIL assert_int_e2 got=%b want=0", rint); end end
            if (n == 3) begin total++; if (rint !== 1'b1) begin bad++; $display("FAIL assert_int_e3 got=%b want=1", rint); end end
        end
        raw_ext = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 9)  begin total++; if (rint !== 1'b1) begin bad++; $display("FAIL deassert_int_e9 got=%b want=1", rint); end end
            if (k == 10) begin total++; if (rint !== 1'b0) begin bad++; $display("FAIL deassert_int_e10 got=%b want=0", rint); end end
        end
        total++; if (cnt !== 8'd3) begin bad++; $display("FAIL release_count got=%0d want=3", cnt); end
    endtask

    task automatic test_pulse_restart();
        raw_ext = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        raw_ext = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 10) begin total++; if (rint !== 1'b1) begin bad++; $display("FAIL restart_int_e10 got=%b want=1", rint); end end
            if (k == 17) begin total++; if (rint !== 1'b1) begin bad++; $display("FAIL restart_int_e17 got=%b want=1", rint); end end
            if (k == 18) begin total++; if (rint !== 1'b0) begin bad++; $display("FAIL restart_int_e18 got=%b want=0", rint); end end
            if (k == 7) raw_ext = 1'b1;
            if (k == 8) raw_ext = 1'b0;
        end
        total++; if (cnt !== 8'd5) begin bad++; $display("FAIL restart_count got=%0d want=5", cnt); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            raw_ext = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            raw_ext = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
        end
        repeat (4) begin @(posedge clk); #1; end
        total++; if (cnt !== 8'd255) begin bad++; $display("FAIL saturate_count got=%0d want=255", cnt); end
    endtask

    task automatic test_async_reset();
        repeat (12) begin @(posedge clk); #1; end
        loop = 1'b1; host_mode = 1'b1;
        @(negedge clk) sw_req = 1'b1;
        @(posedge clk); #1 sw_req = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        total++; if (oe !== 1'b1)   begin bad++; $display("FAIL middrive_oe got=%b want=1", oe); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL middrive_busy got=%b want=1", busy); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (oe !== 1'b0)   begin bad++; $display("FAIL async_oe got=%b want=0", oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", busy); end
        total++; if (rint !== 1'b1) begin bad++; $display("FAIL async_int got=%b want=1", rint); end
        total++; if (cnt !== 8'd0)  begin bad++; $display("FAIL async_count got=%0d want=0", cnt); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sw_request();
        test_host_mode_off();
        test_back_to_back();
        test_release();
        test_pulse_restart();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
